base_op_dispatcher: RTL

- Upstream stage of the base-selecting router.
- Accepts operation requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one request at a time to the router, holding operands stable, and waits for the router's valid with a timeout.
- Returns result and status over a valid/ready output interface.

---
 rtl/base_dispatch_pkg.sv | 42 ++++
 rtl/dispatch_fifo.sv | 80 ++++++++
 rtl/base_op_dispatcher.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/base_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// base_dispatch_pkg
// Shared definitions for the base-selecting router's dispatcher stage:
//   - opcode set shared with the router and ALUs (OP_ADD .. OP_SHR)
//   - request record stored in the dispatch FIFO ({op, a, b}, 36 bits)
//   - dispatcher state encoding
//   - trap result and the divide-by-zero predicate
// ---------------------------------------------------------------------------
package base_dispatch_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;

    localparam logic [15:0] DIVZ_RESULT = 16'hFFFF;

    // One queued request; field order gives the {op, a, b} entry layout.
    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        OUT   = 2'b11
    } state_t;

    // True when the request is a division whose divisor is zero.
    function automatic logic is_div_by_zero(input req_t req);
        return (req.op == OP_DIV) && (req.b == 16'h0000);
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// ---------------------------------------------------------------------------
// dispatch_fifo
// Synchronous request FIFO, DEPTH entries (power of two) of {op, a, b}.
// The head entry is presented combinationally on pop_data while not empty.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, push_data write request (ignored when full)
//   pop,  pop_data  read request (ignored when empty), head entry
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module dispatch_fifo
    import base_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  req_t                       push_data,
    input  logic                       pop,
    output req_t                       pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    req_t          mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/base_op_dispatcher.sv
// ---------------------------------------------------------------------------
// base_op_dispatcher
// Upstream stage of the base-selecting router. Buffers requests in a FIFO,
// issues one at a time to the router (ISSUE settles base selection with the
// enable low, WAIT raises the enable and waits for rt_valid up to TIMEOUT
// cycles) and returns the result over a valid/ready response port.
//
// Optional build macro DIVZ_TRAP_EN: a DIV with b == 0 is answered directly
// with DIVZ_RESULT and out_divz = 1 without involving the router. Without
// the macro out_divz is tied 0 and such ops go to the router normally.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   in_valid/in_ready             request handshake; in_a, in_b, in_op
//   rt_enable, rt_operand_a/b,    router request (registered)
//   rt_operation
//   rt_result, rt_valid           router response (sampled only in WAIT)
//   out_valid/out_ready           response handshake; out_result, out_op,
//   out_timeout, out_divz         flags (registered)
//   count                         FIFO occupancy
//   busy                          op in progress or requests queued
// ---------------------------------------------------------------------------
module base_op_dispatcher
    import base_dispatch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_a,
    input  logic [15:0]                in_b,
    input  logic [3:0]                 in_op,
    output logic                       rt_enable,
    output logic [15:0]                rt_operand_a,
    output logic [15:0]                rt_operand_b,
    output logic [3:0]                 rt_operation,
    input  logic [15:0]                rt_result,
    input  logic                       rt_valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_result,
    output logic [3:0]                 out_op,
    output logic                       out_timeout,
    output logic                       out_divz,
    output logic [$clog2(DEPTH+1)-1:0] count
    ,
    output logic                       busy
);

    localparam int               TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_r;
    state_t        next_state_s;
    req_t          head_s;
    req_t          push_req_s;
    req_t          op_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          capture_s;
    logic          expire_s;
    logic          done_s;
    logic          rt_enable_r;
    logic          out_valid_r;
    logic [15:0]   out_result_r;
    logic [3:0]    out_op_r;
    logic          out_timeout_r;
`ifdef DIVZ_TRAP_EN
    logic          trap_s;
    logic          out_divz_r;
`endif

    assign push_req_s = '{op: in_op, a: in_a, b: in_b};
    assign in_ready   = ~fifo_full_s;
    assign push_s     = in_valid && in_ready;

    dispatch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_req_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (count)
    );

    // Router operands come straight from the op register so they stay stable
    // from ISSUE through the end of WAIT.
    assign rt_enable    = rt_enable_r;
    assign rt_operand_a = op_r.a;
    assign rt_operand_b = op_r.b;
    assign rt_operation = op_r.op;
    assign out_valid    = out_valid_r;
    assign out_result   = out_result_r;
    assign out_op       = out_op_r;
    assign out_timeout  = out_timeout_r;
`ifdef DIVZ_TRAP_EN
    assign out_divz     = out_divz_r;
`else
    assign out_divz     = 1'b0;
`endif
    assign busy = (state_r != IDLE) || (count != '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        capture_s    = 1'b0;
        expire_s     = 1'b0;
        done_s       = 1'b0;
`ifdef DIVZ_TRAP_EN
        trap_s       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
`ifdef DIVZ_TRAP_EN
                    if (is_div_by_zero(head_s)) begin
                        trap_s       = 1'b1;
                        next_state_s = OUT;
                    end else begin
                        next_state_s = ISSUE;
                    end
`else
                    next_state_s = ISSUE;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                next_state_s = WAIT;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still wins.
                if (rt_valid) begin
                    capture_s    = 1'b1;
                    next_state_s = OUT;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    expire_s     = 1'b1;
                    next_state_s = OUT;
                end else begin
                    next_state_s = WAIT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Op register, loaded from the FIFO head on every pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r <= '0;
        end else if (pop_s) begin
            op_r <= head_s;
        end else begin
            op_r <= op_r;
        end
    end

    // WAIT-cycle counter; idles at zero so each WAIT entry starts from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Router enable and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rt_enable_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_result_r  <= 16'h0000;
            out_op_r      <= 4'h0;
            out_timeout_r <= 1'b0;
        end else begin
            rt_enable_r <= (next_state_s == WAIT);
            if (capture_s) begin
                out_valid_r   <= 1'b1;
                out_result_r  <= rt_result;
                out_op_r      <= op_r.op;
                out_timeout_r <= 1'b0;
            end else if (expire_s) begin
                out_valid_r   <= 1'b1;
                out_result_r  <= 16'h0000;
                out_op_r      <= op_r.op;
                out_timeout_r <= 1'b1;
            end
`ifdef DIVZ_TRAP_EN
            else if (trap_s) begin
                out_valid_r   <= 1'b1;
                out_result_r  <= DIVZ_RESULT;
                out_op_r      <= head_s.op;
                out_timeout_r <= 1'b0;
            end
`endif
            else if (done_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

`ifdef DIVZ_TRAP_EN
    // Divide-by-zero flag: set by a trap, cleared by any router-path response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_divz_r <= 1'b0;
        end else if (trap_s) begin
            out_divz_r <= 1'b1;
        end else if (capture_s || expire_s) begin
            out_divz_r <= 1'b0;
        end else begin
            out_divz_r <= out_divz_r;
        end
    end
`endif

endmodule
